// File: rtl/pconv_feeder.sv
// pconv_feeder: sequences one pointwise-conv pass. Per output channel it fetches
// a weight row with its bias and shift, then streams every pixel word as a
// tagged beat. The read-to-beat latency is two cycles. The weight registers
// change only after the last beat of the previous channel has left.
module pconv_feeder #(
    parameter int N              = 16,
    parameter int INPUT_CHANNEL  = 3,
    parameter int OUTPUT_CHANNEL = 8,
    parameter int PIXELS         = 784,
    parameter int PIX_W          = 10,
    parameter int OC_W           = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      hold,
    output logic                      busy,
    output logic                      done,
    output logic                      fmap_rd_en,
    output logic [PIX_W-1:0]          fmap_rd_addr,
    input  logic [INPUT_CHANNEL*N-1:0] fmap_rd_data,
    output logic                      wt_rd_en,
    output logic [OC_W-1:0]           wt_rd_addr,
    input  logic [INPUT_CHANNEL*N-1:0] wt_rd_data,
    input  logic [31:0]               bias_rd_data,
    input  logic [4:0]                shift_rd_data,
    output logic                      input_vld,
    output logic [INPUT_CHANNEL*N-1:0] input_din,
    output logic [INPUT_CHANNEL*N-1:0] weight_din,
    output logic [31:0]               bias_din,
    output logic [4:0]                shift_din,
    output logic [OC_W-1:0]           beat_oc,
    output logic [PIX_W-1:0]          beat_pix,
    output logic                      beat_last
);

    localparam int DW = INPUT_CHANNEL * N;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);
    localparam logic [OC_W-1:0]  OC_LAST  = OC_W'(OUTPUT_CHANNEL - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_WAIT_W, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [OC_W-1:0]   oc_q, oc_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              drain_q, drain_d;

    // stage 1: read issued, data arrives from the buffer this cycle
    logic              s1_vld_q, s1_vld_d;
    logic [OC_W-1:0]   s1_oc_q, s1_oc_d;
    logic [PIX_W-1:0]  s1_pix_q, s1_pix_d;
    logic              s1_last_q, s1_last_d;

    // stage 2: registered beat presented to the conv unit
    logic              vld_q, vld_d;
    logic [DW-1:0]     din_q, din_d;
    logic [OC_W-1:0]   boc_q, boc_d;
    logic [PIX_W-1:0]  bpix_q, bpix_d;
    logic              blast_q, blast_d;

    logic [DW-1:0]     weight_q, weight_d;
    logic [31:0]       bias_q, bias_d;
    logic [4:0]        shift_q, shift_d;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next-state logic; abort overrides everything including start
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (start) state_d = S_LOAD_W;
                S_LOAD_W: state_d = S_WAIT_W;
                S_WAIT_W: state_d = S_STREAM;
                S_STREAM: if (!hold && pix_q == PIX_LAST)
                              state_d = (oc_q == OC_LAST) ? S_DRAIN : S_LOAD_W;
                S_DRAIN:  if (drain_q) state_d = S_DONE;
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // state-decoded outputs and read strobes
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        fmap_rd_en = 1'b0;
        wt_rd_en   = 1'b0;
        case (state_q)
            S_LOAD_W: begin
                busy     = 1'b1;
                wt_rd_en = 1'b1;
            end
            S_WAIT_W, S_DRAIN: busy = 1'b1;
            S_STREAM: begin
                busy       = 1'b1;
                fmap_rd_en = ~hold;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // channel/pixel counters and the two-cycle drain timer
    always_comb begin
        oc_d    = oc_q;
        pix_d   = pix_q;
        drain_d = 1'b0;
        if (abort || state_q == S_IDLE) begin
            oc_d  = '0;
            pix_d = '0;
        end else begin
            if (fmap_rd_en) begin
                if (pix_q == PIX_LAST) begin
                    pix_d = '0;
                    oc_d  = (oc_q == OC_LAST) ? '0 : oc_q + OC_W'(1);
                end else begin
                    pix_d = pix_q + PIX_W'(1);
                end
            end
            if (state_q == S_DRAIN) drain_d = ~drain_q;
        end
    end

    // beat pipeline; abort flushes both stages so no in-flight beat escapes
    always_comb begin
        s1_vld_d  = fmap_rd_en & ~abort;
        s1_oc_d   = oc_q;
        s1_pix_d  = pix_q;
        s1_last_d = (oc_q == OC_LAST) && (pix_q == PIX_LAST);
        vld_d     = s1_vld_q & ~abort;
        blast_d   = s1_vld_q & s1_last_q & ~abort;
        din_d     = s1_vld_q ? fmap_rd_data : din_q;
        boc_d     = s1_vld_q ? s1_oc_q : boc_q;
        bpix_d    = s1_vld_q ? s1_pix_q : bpix_q;
    end

    // weight/bias/shift capture at the end of WAIT_W; held through abort
    always_comb begin
        weight_d = weight_q;
        bias_d   = bias_q;
        shift_d  = shift_q;
        if (state_q == S_WAIT_W && !abort) begin
            weight_d = wt_rd_data;
            bias_d   = bias_rd_data;
            shift_d  = shift_rd_data;
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oc_q      <= '0;
            pix_q     <= '0;
            drain_q   <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_oc_q   <= '0;
            s1_pix_q  <= '0;
            s1_last_q <= 1'b0;
            vld_q     <= 1'b0;
            din_q     <= '0;
            boc_q     <= '0;
            bpix_q    <= '0;
            blast_q   <= 1'b0;
            weight_q  <= '0;
            bias_q    <= '0;
            shift_q   <= '0;
        end else begin
            oc_q      <= oc_d;
            pix_q     <= pix_d;
            drain_q   <= drain_d;
            s1_vld_q  <= s1_vld_d;
            s1_oc_q   <= s1_oc_d;
            s1_pix_q  <= s1_pix_d;
            s1_last_q <= s1_last_d;
            vld_q     <= vld_d;
            din_q     <= din_d;
            boc_q     <= boc_d;
            bpix_q    <= bpix_d;
            blast_q   <= blast_d;
            weight_q  <= weight_d;
            bias_q    <= bias_d;
            shift_q   <= shift_d;
        end
    end

    assign fmap_rd_addr = pix_q;
    assign wt_rd_addr   = oc_q;
    assign input_vld    = vld_q;
    assign input_din    = din_q;
    assign beat_oc      = boc_q;
    assign beat_pix     = bpix_q;
    assign beat_last    = blast_q;
    assign weight_din   = weight_q;
    assign bias_din     = bias_q;
    assign shift_din    = shift_q;

endmodule
